// File: rtl/exec_core.sv
// Self-sequencing execution core: fetch line, read two operands, run the ALU, write back, advance or branch.
// Optional ALU watchdog enabled by defining EXEC_CORE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | line_req high until line_vld, opcode decode
// RD1   | read src1 from RAM
// RD2   | capture src1 data, read src2
// CALC  | capture src2 data, then drive ALU until alu_done
// WRITE | write latched result to dst
// HALT  | halt opcode seen, done held until start
// ERR   | ip overflow, bad branch target or ALU timeout
module exec_core #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int IP_W        = 8,
  parameter int OPC_W       = 8,
  parameter int PROG_LEN    = 256,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      line_req,
  output logic [IP_W-1:0]           ip,
  input  logic                      line_vld,
  input  logic [OPC_W+3*ADDR_W-1:0] line,
  output logic                      ram_rd_en,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  input  logic                      ram_busy,
  output logic                      alu_en,
  output logic [OPC_W-1:0]          alu_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_done,
  input  logic                      alu_jump
);

  localparam int LINE_W = OPC_W + 3*ADDR_W;

  if (ALU_TIMEOUT < 1 || PROG_LEN < 1 || PROG_LEN > 2**IP_W) begin : g_param_check
    $error("exec_core: ALU_TIMEOUT/PROG_LEN out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RD1, S_RD2, S_CALC, S_WRITE, S_HALT, S_ERR
  } state_t;

  state_t              state, state_nxt;
  logic                first_q;
  logic [OPC_W-1:0]    opc;
  logic [ADDR_W-1:0]   dst, src1, src2;
  logic [DATA_W-1:0]   res;
  logic                calc_live;
  logic                to_expire;
  logic                tgt_ok;
  logic                last_ip;
  logic                start_ok;

  assign calc_live = (state == S_CALC) && !first_q;
  assign tgt_ok    = 32'(alu_result) < 32'(PROG_LEN);
  assign last_ip   = 32'(ip) == 32'(PROG_LEN - 1);
  assign start_ok  = start && (state == S_IDLE || state == S_HALT || state == S_ERR);

`ifdef EXEC_CORE_TIMEOUT_EN
  localparam int TO_W = $clog2(ALU_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Reloaded outside CALC, counts down once per cycle alu_en is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 to_cnt <= '0;
    else if (state != S_CALC)  to_cnt <= TO_W'(ALU_TIMEOUT);
    else if (calc_live)        to_cnt <= to_cnt - 1'b1;
  end

  assign to_expire = calc_live && !alu_done && (to_cnt == TO_W'(1));
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    line_req  = 1'b0;
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    alu_en    = 1'b0;
    case (state)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        line_req = 1'b1;
        if (line_vld)
          state_nxt = (line[LINE_W-1 -: OPC_W] == '1) ? S_HALT : S_RD1;
      end
      S_RD1: begin
        ram_rd_en = 1'b1;
        ram_addr  = src1;
        if (!ram_busy) state_nxt = S_RD2;
      end
      S_RD2: begin
        ram_rd_en = 1'b1;
        ram_addr  = src2;
        if (!ram_busy) state_nxt = S_CALC;
      end
      S_CALC: begin
        alu_en = calc_live;
        if (calc_live && alu_done) begin
          if (!alu_jump)   state_nxt = S_WRITE;
          else if (tgt_ok) state_nxt = S_FETCH;
          else             state_nxt = S_ERR;
        end else if (to_expire) begin
          state_nxt = S_ERR;
        end
      end
      S_WRITE: begin
        ram_wr_en = 1'b1;
        ram_addr  = dst;
        ram_wdata = res;
        if (!ram_busy) state_nxt = last_ip ? S_ERR : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_HALT) && (state != S_ERR);
  assign done = (state == S_HALT);
  assign err  = (state == S_ERR);
  assign alu_opcode = opc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      first_q <= 1'b0;
      ip      <= '0;
      opc     <= '0;
      dst     <= '0;
      src1    <= '0;
      src2    <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      res     <= '0;
    end else begin
      state   <= state_nxt;
      // Marks the first cycle in a state; RAM read data lands exactly then.
      first_q <= (state_nxt != state);
      if (state == S_FETCH && line_vld)
        {opc, dst, src1, src2} <= line;
      if (state == S_RD2 && first_q)
        alu_a <= ram_rdata;
      if (state == S_CALC && first_q)
        alu_b <= ram_rdata;
      if (calc_live && alu_done && !alu_jump)
        res <= alu_result;

      if (start_ok)
        ip <= '0;
      else if (calc_live && alu_done && alu_jump && tgt_ok)
        ip <= alu_result[IP_W-1:0];
      else if (state == S_WRITE && !ram_busy && !last_ip)
        ip <= ip + 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_core.sv
// Directed bench for exec_core: line/RAM/ALU responders, a vector table of instructions, and hand sequences.
module tb_exec_core;
  localparam int DW = 8, AW = 8, IW = 8, OW = 8, PL = 8, TO = 16;
  localparam int LW = OW + 3*AW;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic busy, done, err, line_req, line_vld;
  logic [IW-1:0] ip;
  logic [LW-1:0] line;
  logic ram_rd_en, ram_wr_en, ram_busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic alu_en, alu_done, alu_jump;
  logic [OW-1:0] alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_result;

  exec_core #(.DATA_W(DW), .ADDR_W(AW), .IP_W(IW), .OPC_W(OW), .PROG_LEN(PL), .ALU_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err(err),
    .line_req(line_req), .ip(ip), .line_vld(line_vld), .line(line),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_done(alu_done), .alu_jump(alu_jump)
  );

  always #5 clk = ~clk;

  logic [LW-1:0] prog [PL];
  logic [DW-1:0] mem [256];
  int stall_done = 0, busy_until = 0, alu_cycles = 0, alu_done_at = 0;
  bit alu_never = 1'b0;
  int wr_cnt = 0, rd_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;
  int nvec = 0, nmis = 0;

  assign line     = prog[ip[2:0]];
  assign line_vld = line_req;
  assign ram_busy = stall_done < busy_until;
  assign alu_done = alu_en && !alu_never && (alu_cycles >= alu_done_at);
  assign alu_jump = (alu_opcode == 8'h10);

  always_comb begin
    alu_result = alu_a;
    case (alu_opcode)
      8'h01: alu_result = alu_a + alu_b;
      8'h02: alu_result = alu_a - alu_b;
      8'h03: alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a;
    endcase
  end

  always @(posedge clk) begin
    if ((ram_rd_en || ram_wr_en) && ram_busy) stall_done <= stall_done + 1;
    if (ram_rd_en && !ram_busy) begin
      ram_rdata <= mem[ram_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (ram_wr_en && !ram_busy) begin
      last_wr_addr <= ram_addr;
      last_wr_data <= ram_wdata;
      wr_cnt       <= wr_cnt + 1;
    end
    if (alu_en) alu_cycles <= alu_cycles + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request exclusivity and stall stability, watched every cycle.
  logic stall_pend = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  always @(negedge clk) begin
    if (rstn) begin
      if (line_req || ram_rd_en || ram_wr_en || alu_en)
        chk("one_req", 64'($countones({line_req, ram_rd_en, ram_wr_en, alu_en})), 64'd1);
      if (stall_pend) chk("stall_hold", {ram_rd_en, ram_addr}, {1'b1, stall_addr});
      stall_pend = ram_rd_en && ram_busy;
      stall_addr = ram_addr;
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called at a negedge in FETCH; returns cycles until the next fetch, HALT or ERR.
  task automatic step(output int n);
    logic prev_lr;
    prev_lr = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (done || err) break;
      if (line_req && !prev_lr) break;
      prev_lr = line_req;
    end
    if (n >= 300) chk("step_budget", 64'(n), 64'd0);
  endtask

  typedef struct {
    int ip; logic [31:0] line; logic [7:0] va, vb;
    int busy, wt, cyc, nip; logic [7:0] wd; int kind;  // kind: 0 write, 1 branch, 2 halt
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n, w0, r0;
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < PL; i++) prog[i] = '0;

    vecs[0] = '{0, 32'h01201011, 8'h03, 8'h04, 0, 0, 6, 1, 8'h07, 0};
    vecs[1] = '{1, 32'h02211213, 8'h09, 8'h02, 3, 0, 9, 2, 8'h07, 0};
    vecs[2] = '{2, 32'h03221415, 8'hF0, 8'h3C, 0, 2, 8, 3, 8'hCC, 0};
    vecs[3] = '{3, 32'h10001616, 8'h05, 8'h05, 1, 0, 6, 5, 8'h00, 1};
    vecs[4] = '{5, 32'h01231017, 8'h80, 8'h90, 0, 0, 6, 6, 8'h10, 0};
    vecs[5] = '{6, 32'hFF000000, 8'h00, 8'h00, 0, 0, 1, 6, 8'h00, 2};

    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, done, err, line_req, ram_rd_en, ram_wr_en, alu_en,
                       ip, ram_addr, ram_wdata, alu_opcode, alu_a, alu_b}, 64'd0);
    @(negedge clk) rstn = 1'b1;

    do_start();
    chk("start_fetch", {busy, line_req, ip}, {1'b1, 1'b1, 8'd0});
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      chk("vec_ip", 64'(ip), 64'(v.ip));
      prog[v.ip] = v.line;
      mem[v.line[15:8]] = v.va;
      mem[v.line[7:0]]  = v.vb;
      busy_until  = stall_done + v.busy;
      alu_done_at = alu_cycles + v.wt;
      w0 = wr_cnt;
      r0 = rd_cnt;
      step(n);
      chk("vec_cycles", 64'(n), 64'(v.cyc));
      if (v.kind == 2) begin
        chk("halt_flags", {done, err, busy}, 3'b100);
        chk("halt_no_ram", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);
      end else begin
        chk("vec_next_ip", {line_req, ip}, {1'b1, 8'(v.nip)});
        chk("vec_wr_cnt", 64'(wr_cnt - w0), (v.kind == 0) ? 64'd1 : 64'd0);
        if (v.kind == 0) chk("vec_wr", {last_wr_addr, last_wr_data}, {v.line[23:16], v.wd});
      end
    end

    repeat (3) @(negedge clk);
    chk("halt_held", {done, busy}, 2'b10);
    do_start();
    chk("halt_restart", {done, busy, line_req, ip}, {1'b0, 1'b1, 1'b1, 8'd0});

    // Branch beyond program length.
    do_reset();
    prog[0] = 32'h10001717;
    mem[8'h17] = 8'hFF;
    do_start();
    w0 = wr_cnt;
    step(n);
    chk("bad_tgt_cycles", 64'(n), 64'd5);
    chk("bad_tgt_flags", {err, busy, done}, 3'b100);
    chk("bad_tgt_no_wr", 64'(wr_cnt - w0), 64'd0);
    do_start();
    chk("err_restart", {err, line_req, ip}, {1'b0, 1'b1, 8'd0});

    // Last legal line completes its write, then ERR; start while busy is ignored.
    do_reset();
    prog[0] = 32'h10001818;
    mem[8'h18] = 8'h07;
    prog[7] = 32'h01241011;
    mem[8'h10] = 8'h03;
    mem[8'h11] = 8'h04;
    do_start();
    step(n);
    chk("jump7_cycles", 64'(n), 64'd5);
    chk("jump7_ip", {line_req, ip}, {1'b1, 8'd7});
    do_start();
    chk("start_ignored", {busy, ram_rd_en, ip}, {1'b1, 1'b1, 8'd7});
    w0 = wr_cnt;
    step(n);
    chk("end_err", {err, busy, ip}, {1'b1, 1'b0, 8'd7});
    chk("end_wr", {64'(wr_cnt - w0), last_wr_addr, last_wr_data}, {64'd1, 8'h24, 8'h07});

    // Asynchronous reset while in RD2.
    do_reset();
    prog[0] = 32'h01261011;
    do_start();
    @(negedge clk);
    @(negedge clk);
    chk("rd2_addr", {ram_rd_en, ram_addr}, {1'b1, 8'h11});
    w0 = wr_cnt;
    #1 rstn = 1'b0;
    #1 chk("async_reset", {busy, done, err, line_req, ram_rd_en, ram_wr_en, alu_en,
                           ip, ram_addr, ram_wdata, alu_opcode, alu_a, alu_b}, 64'd0);
    @(negedge clk) rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_idle", {64'(wr_cnt - w0), busy}, {64'd0, 1'b0});

    // ALU never answers.
    prog[0] = 32'h01251011;
    alu_never = 1'b1;
    do_start();
`ifdef EXEC_CORE_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (err) break;
      if (alu_en) n++;
      @(negedge clk);
    end
    chk("timeout_len", 64'(n), 64'(TO));
    chk("timeout_err", {err, alu_en, busy}, 3'b100);
`else
    repeat (100) @(negedge clk);
    chk("no_timeout", {alu_en, busy, err}, 3'b110);
`endif
    alu_never = 1'b0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/exec_core.md
# exec_core

Parametrised, self-sequencing execution core. It replaces the externally sequenced core with an internal FSM. It fetches three-operand instruction lines, reads two operands from RAM, drives a multi-cycle ALU, writes the result back and advances or branches the instruction pointer. It sits between line memory, data RAM and the ALU, and honours back-pressure from all three.

## Interface
Parameters:
- DATA_W, 8, operand/result width
- ADDR_W, 8, RAM address width (dst/src1/src2 fields)
- IP_W, 8, instruction pointer width
- OPC_W, 8, opcode field width; line width LINE_W = OPC_W + 3*ADDR_W (derived)
- PROG_LEN, 256, number of valid lines; legal ip range 0..PROG_LEN-1
- ALU_TIMEOUT, 16, max CALC cycles waiting for alu_done

Ports:
- clk  in  1  clock; one clock, all logic on rising edge
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  begin execution at ip 0; ignored while busy=1
- busy  out  1  high from start acceptance until HALT or ERR
- done  out  1  held high in HALT until next start
- err  out  1  held high in ERR until next start
- line_req  out  1  line fetch request, held until line_vld
- ip  out  IP_W  current instruction pointer (line address)
- line_vld  in  1  line valid; line captured when line_req & line_vld
- line  in  LINE_W  {opcode, dst, src1, src2}, MSB first
- ram_rd_en, ram_wr_en  out  1  RAM requests, held until accepted (ram_busy=0)
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  write data
- ram_rdata  in  DATA_W  read data, valid the cycle after read acceptance
- ram_busy  in  1  RAM back-pressure
- alu_en  out  1  ALU operation request, held until alu_done
- alu_opcode  out  OPC_W; alu_a, alu_b  out  DATA_W  operands
- alu_result  in  DATA_W; alu_done  in  1; alu_jump  in  1  (qualified by alu_done: result is branch target)

## Operation
- States: IDLE, FETCH, RD1, RD2, CALC, WRITE, HALT, ERR.
- IDLE: start=1 -> ip<=0, FETCH. From HALT/ERR, start=1 -> clear done/err, ip<=0, FETCH.
- FETCH: line_req=1. On line_vld, capture line. Opcode all-ones -> HALT (no RAM access). Otherwise -> RD1.
- RD1: ram_rd_en=1, ram_addr=src1. On accept -> RD2.
- RD2:
  - First cycle captures ram_rdata into alu_a.
  - ram_rd_en=1, ram_addr=src2. On accept -> CALC.
- CALC:
  - First cycle captures ram_rdata into alu_b.
  - From the second cycle, alu_en=1 with alu_opcode/alu_a/alu_b stable.
  - On alu_done with alu_jump=1: ip<=alu_result[IP_W-1:0], go FETCH, no write.
  - On alu_done with alu_jump=0: latch result, go WRITE.
- WRITE: ram_wr_en=1, ram_addr=dst, ram_wdata=latched result. On accept:
  - ip==PROG_LEN-1 -> ERR.
  - Otherwise ip<=ip+1, FETCH.
- A branch target >= PROG_LEN -> ERR instead of FETCH.
- Address/data fields are unsigned. ip increment is never allowed to wrap.
- start while busy=1 has no effect.

## Timing
- Reset: every output 0, state IDLE, ip=0, internal operand/result registers 0.
- Reset asserted mid-instruction aborts immediately. No pending RAM write completes after reset.
- Minimum latency with zero stalls: FETCH 1, RD1 1, RD2 1, CALC 2, WRITE 1 = 6 cycles/instruction; branch = 5 cycles.
- Each stall cycle (line_vld=0, ram_busy=1, alu_done=0) adds exactly one cycle. Requests and addresses stay stable during stalls.
- ram_rd_en and ram_wr_en are never high in the same cycle. At most one of line_req/ram_rd_en/ram_wr_en/alu_en is high per cycle.
- done/err rise the cycle after the transition decision and stay high until start.

## Configuration
- EXEC_CORE_TIMEOUT_EN defined:
  - CALC counts alu_en cycles.
  - If alu_done is still low after ALU_TIMEOUT cycles, drop alu_en and go to ERR.
- Undefined: CALC waits indefinitely for alu_done; no counter is synthesised.

## Test plan
- Single ADD line {01,20,10,11}, RAM[10]=3, RAM[11]=4, ALU returns 7 with no stalls -> RAM[20]=7, ip 0->1, exactly 6 cycles.
- ram_busy held high 3 cycles during RD1 -> ram_rd_en/ram_addr=src1 stable for 4 cycles; instruction takes 9 cycles total.
- Branch: alu_jump=1, alu_result=5 -> no RAM write, next line_req with ip=5. Target 0xFF with PROG_LEN=8 -> err=1, busy=0.
- HALT line (opcode 0xFF) at ip=2 -> done=1, no RAM access. A later start=1 -> done=0, ip=0, FETCH.
- Non-halting line at ip=PROG_LEN-1 -> write completes, then err=1. rstn pulsed low mid-RD2 -> all outputs 0 asynchronously, state IDLE.
- With EXEC_CORE_TIMEOUT_EN and ALU_TIMEOUT=16: alu_done never asserted -> alu_en high for 16 cycles, then err=1. Without the macro, still in CALC after 100 cycles.
